// File: rtl/rr_mux_arbiter_pkg.sv
// rtl/rr_mux_arbiter_pkg.sv - shared constants for the round-robin mux arbiter
package rr_mux_arbiter_pkg;

  localparam int N_REQS_MAX = 32;
  localparam int N_REQS_LEGAL [5] = '{2, 4, 8, 16, 32};

  function automatic bit legal_n_reqs(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (N_REQS_LEGAL[i] == n && n <= N_REQS_MAX) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/mux_.sv
// rtl/mux_.sv - generic N-input data mux, index-selected
module mux_ #(
  parameter int WIDTH = 32,
  parameter int N_INS = 4,
  localparam int SEL_WIDTH = $clog2(N_INS)
) (
  input  logic [N_INS-1:0][WIDTH-1:0] in,
  input  logic [SEL_WIDTH-1:0]        sel,
  output logic [WIDTH-1:0]            out
);

  assign out = in[sel];

endmodule

// File: rtl/rr_prio_pick.sv
// rtl/rr_prio_pick.sv - rotating priority encoder, first set bit at or after ptr
module rr_prio_pick
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N_REQS = 4,
  localparam int SEL_WIDTH = $clog2(N_REQS)
) (
  input  logic [N_REQS-1:0]    req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic                 any,
  output logic [SEL_WIDTH-1:0] idx
);

  logic [SEL_WIDTH-1:0] cand;

  // Scan from farthest to nearest so the closest hit to ptr wins; N_REQS is a
  // power of two, so the index addition wraps on its own.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = N_REQS - 1; k >= 0; k--) begin
      cand = ptr + SEL_WIDTH'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter with locked bursts and registered output
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_REQS = 4,
  localparam int SEL_WIDTH = $clog2(N_REQS)
) (
  input  logic                         clk,
  input  logic                         rst_aH,
  input  logic [N_REQS-1:0]            req_valid,
  input  logic [N_REQS-1:0]            req_lock,
  input  logic [N_REQS-1:0][WIDTH-1:0] req_data,
  output logic [N_REQS-1:0]            req_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [SEL_WIDTH-1:0]         out_sel
);

  logic [SEL_WIDTH-1:0] prio_ptr;
  logic                 locked;
  logic [SEL_WIDTH-1:0] lock_idx;

  logic                 pick_any;
  logic [SEL_WIDTH-1:0] pick_idx;
  logic [SEL_WIDTH-1:0] winner;
  logic                 win_valid;
  logic                 can_accept;
  logic                 fire;
  logic [WIDTH-1:0]     mux_data;

  rr_prio_pick #(.N_REQS(N_REQS)) u_pick (
    .req (req_valid),
    .ptr (prio_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // A held lock pins the grant even when the owner is idle: no other requester
  // may slip a beat into the middle of a burst.
  assign winner     = locked ? lock_idx : pick_idx;
  assign win_valid  = locked ? req_valid[lock_idx] : pick_any;
  assign can_accept = !out_valid || out_ready;
  assign fire       = can_accept && win_valid;
  assign req_ready  = fire ? (N_REQS'(1) << winner) : '0;

  mux_ #(.WIDTH(WIDTH), .N_INS(N_REQS)) u_mux (
    .in  (req_data),
    .sel (winner),
    .out (mux_data)
  );

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      prio_ptr  <= '0;
      locked    <= 1'b0;
      lock_idx  <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_sel   <= winner;
      if (req_lock[winner]) begin
        locked   <= 1'b1;
        lock_idx <= winner;
      end else begin
        locked   <= 1'b0;
        prio_ptr <= winner + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared N-input gate-level mux.
- Selects one of N_REQS valid/ready requesters per cycle and drives the mux select with the winner's index.
- Captures the selected data into a registered output stage with a valid/ready handshake.
- Supports multi-beat locked transfers. Used wherever several producers share one downstream port (e.g. issue-to-FU result sharing, memory request funnel).

Parameters:
- WIDTH, 32, data bits per requester.
- N_REQS, 4, number of requesters; legal values 2, 4, 8, 16, 32.
- SEL_WIDTH, $clog2(N_REQS), localparam; width of grant index.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_aH  input  1  asynchronous active-high reset.
- req_valid  input  N_REQS  per-requester valid.
- req_lock  input  N_REQS  per-requester: keep grant after this beat.
- req_data  input  N_REQS x WIDTH  packed [N_REQS-1:0][WIDTH-1:0] request data.
- req_ready  output  N_REQS  one-hot (or zero) accept strobe.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts beat.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_WIDTH  index of the requester whose beat is in out_data.

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_sel=0, prio_ptr=0, locked=0, lock_idx=0. req_ready is combinational and is 0 while out_valid=0 and no req_valid is set.
- can_accept = !out_valid | out_ready (pass-through of downstream ready; no bubble under full throughput).
- Arbitration is combinational each cycle:
  - If locked=0: winner = first i with req_valid[i], scanning prio_ptr, prio_ptr+1, ... mod N_REQS.
  - If locked=1: winner = lock_idx only; other requesters are ignored even if lock_idx is not valid (no grant that cycle).
- req_ready[winner] = can_accept & req_valid[winner]. All other bits are 0. At most one bit is high.
- On a fire (req_valid[w] & req_ready[w]) at the edge:
  - out_data <= req_data[w] (via mux_ with sel=w); out_sel <= w; out_valid <= 1.
  - If req_lock[w]=1: locked <= 1, lock_idx <= w, prio_ptr unchanged.
  - Else: locked <= 0, prio_ptr <= (w+1) mod N_REQS. Wraps from N_REQS-1 to 0.
- No fire and out_ready=1: out_valid <= 0. out_data and out_sel hold their last value.
- out_valid=1 and out_ready=0: out_data, out_sel, out_valid hold. req_ready=0 for all requesters.
- Latency: a request accepted in cycle t appears on out_data in cycle t+1.
- Throughput: 1 beat/cycle while out_ready=1.
- No requests: no state change except out_valid clearing.
- A reset asserted mid-lock or mid-stall discards the held beat and the lock. The first post-reset grant starts from index 0.
- Fairness: with all N requesters continuously valid and unlocked, grants cycle 0,1,...,N-1,0. The maximum wait is N_REQS-1 grants, excluding locked bursts.

Decomposition:
- Shared package: N_REQS legal-value list and a max-N constant. No typedefs needed beyond the packed data array.
- Sub-module rr_prio_pick: inputs req[N], ptr[SEL_WIDTH]; outputs any, idx. Purely combinational rotate + priority encode.
- Data selection reuses the existing mux_ (WIDTH, N_INS=N_REQS) instance, driven by the winner index.
- Registers, lock logic and handshake live in the top module.

Test Plan:
- Reset: assert rst_aH mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately. After release with req_valid=4'b1111, the first grant is index 0.
- Round-robin: N_REQS=4, req_valid=4'b1111 constant, out_ready=1, req_data[i]=32'hA0+i -> out_data sequence A0,A1,A2,A3,A0 on consecutive cycles; req_ready one-hot each cycle.
- Sparse and wrap: prio_ptr=3, req_valid=4'b0010 -> grant 1, prio_ptr becomes 2. Next cycle req_valid=4'b1001 -> grant 3, then 0.
- Backpressure: out_ready=0 for 3 cycles after a beat from requester 2 -> out_data/out_sel/out_valid stable, req_ready=0. On out_ready=1, the next grant issues in the same cycle with no bubble.
- Lock: requester 1 sends 3 beats with req_lock=1,1,0 while req_valid=4'b1111 -> out_sel=1,1,1, then grant 2. Requester 1 drops valid mid-lock for 2 cycles -> no grants during those cycles.
- Width/size sweep: N_REQS=2 and 32, WIDTH=1 and 64, random valid/ready/lock for 10k cycles. Scoreboard checks data order per requester, at most one req_ready, and no starvation beyond N_REQS-1 unlocked grants.
